// File: rtl/raw_output_display_if.sv
// Bus between the processor's RawOutput port and the display block.
// The display itself is the slave; the CPU side (or a bench) is the master.
interface raw_output_display_if;
    logic [7:0] RawOutput;
    logic       hex_mode;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;
    logic [7:0] update_count;

    modport master (
        output RawOutput, hex_mode,
        input  seg, an, busy, update_count
    );

    modport slave (
        input  RawOutput, hex_mode,
        output seg, an, busy, update_count
    );
endinterface

// File: rtl/raw_output_display.sv
// Captures the processor output byte, converts it to BCD with a sequential
// double-dabble engine and scans it onto a 4-digit active-low 7-segment display.
module raw_output_display #(
    parameter int REFRESH_BITS = 18
) (
    input  logic                 clk,
    input  logic                 Reset,
    raw_output_display_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

    state_t                  state_q, state_d;
    logic [7:0]              shown_q, shown_d;
    logic [7:0]              conv_src_q, conv_src_d;
    logic [19:0]             shift_q, shift_d;
    logic [2:0]              bit_cnt_q, bit_cnt_d;
    logic [11:0]             bcd_q, bcd_d;
    logic [7:0]              count_q, count_d;
    logic [REFRESH_BITS-1:0] scan_q;
    logic [6:0]              seg_q, seg_d;
    logic [3:0]              an_q, an_d;
    logic [19:0]             shift_adj;
    logic [1:0]              slot;
    logic [3:0]              digit;
    logic                    blank;

    function automatic logic [6:0] font(input logic [3:0] v);
        case (v)
            4'h0: font = 7'h40;
            4'h1: font = 7'h79;
            4'h2: font = 7'h24;
            4'h3: font = 7'h30;
            4'h4: font = 7'h19;
            4'h5: font = 7'h12;
            4'h6: font = 7'h02;
            4'h7: font = 7'h78;
            4'h8: font = 7'h00;
            4'h9: font = 7'h10;
            4'hA: font = 7'h08;
            4'hB: font = 7'h03;
            4'hC: font = 7'h46;
            4'hD: font = 7'h21;
            4'hE: font = 7'h06;
            default: font = 7'h0E;
        endcase
    endfunction

    // Add-3 correction on each BCD nibble before the shift.
    assign shift_adj[7:0] = shift_q[7:0];
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dabble
            assign shift_adj[8+4*gi +: 4] = (shift_q[8+4*gi +: 4] >= 4'd5)
                                          ? shift_q[8+4*gi +: 4] + 4'd3
                                          : shift_q[8+4*gi +: 4];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        shown_d    = shown_q;
        conv_src_d = conv_src_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        bcd_d      = bcd_q;
        count_d    = count_q;
        case (state_q)
            IDLE: begin
                if (bus.RawOutput != shown_q) begin
                    conv_src_d = bus.RawOutput;
                    shift_d    = {12'b0, bus.RawOutput};
                    bit_cnt_d  = 3'd0;
                    state_d    = CONVERT;
                end
            end
            CONVERT: begin
                shift_d   = {shift_adj[18:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7)
                    state_d = LOAD;
            end
            LOAD: begin
                bcd_d   = shift_q[19:8];
                shown_d = conv_src_q;
                count_d = count_q + 8'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Digit selection works from next-state values so new digits appear on the
    // same edge that commits them.
    assign slot = scan_q[REFRESH_BITS-1 -: 2];

    always_comb begin
        digit = 4'd0;
        blank = 1'b0;
        case (slot)
            2'd0: digit = bus.hex_mode ? shown_d[3:0] : bcd_d[3:0];
            2'd1: begin
                digit = bus.hex_mode ? shown_d[7:4] : bcd_d[7:4];
                blank = !bus.hex_mode && (bcd_d[11:8] == 4'd0) && (bcd_d[7:4] == 4'd0);
            end
            2'd2: begin
                digit = bcd_d[11:8];
                blank = bus.hex_mode || (bcd_d[11:8] == 4'd0);
            end
            default: digit = count_d[3:0];
        endcase
        seg_d = blank ? 7'h7F : font(digit);
        an_d  = ~(4'b0001 << slot);
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            shown_q    <= 8'd0;
            conv_src_q <= 8'd0;
            shift_q    <= 20'd0;
            bit_cnt_q  <= 3'd0;
            bcd_q      <= 12'd0;
            count_q    <= 8'd0;
            scan_q     <= '0;
            seg_q      <= 7'h7F;
            an_q       <= 4'b1111;
        end else begin
            state_q    <= state_d;
            shown_q    <= shown_d;
            conv_src_q <= conv_src_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            bcd_q      <= bcd_d;
            count_q    <= count_d;
            scan_q     <= scan_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign bus.seg          = seg_q;
    assign bus.an           = an_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.update_count = count_q;

endmodule

// File: tb/tb_raw_output_display.sv
// Directed bench for raw_output_display with a 4-bit scan counter.
module tb_raw_output_display;

    logic clk;
    logic Reset;
    int   vectors;
    int   miscompares;

    raw_output_display_if bus();

    raw_output_display #(.REFRESH_BITS(4)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Waits (bounded) for the scan to reach digit k and returns its segments.
    task automatic get_seg(input int k, output logic [6:0] s, output bit ok);
        logic [3:0] want;
        want = ~(4'b0001 << k);
        ok   = 1'b0;
        s    = 7'hxx;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (bus.an === want) begin
                s  = bus.seg;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_busy(output int high, output int pulses);
        logic prev;
        prev   = 1'b0;
        high   = 0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) high++;
            if (bus.busy === 1'b1 && !prev) pulses++;
            prev = bus.busy;
        end
    endtask

    task automatic test_reset;
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an;
        exp_seg[0] = 7'h40; exp_seg[1] = 7'h7F; exp_seg[2] = 7'h7F; exp_seg[3] = 7'h40;
        Reset = 1'b1;
        bus.RawOutput = 8'd0;
        bus.hex_mode  = 1'b0;
        #50;
        vectors++;
        if (bus.an !== 4'b1111 || bus.seg !== 7'h7F || bus.busy !== 1'b0 || bus.update_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_state an=%b seg=%h busy=%b cnt=%0d expected an=1111 seg=7f busy=0 cnt=0",
                     bus.an, bus.seg, bus.busy, bus.update_count);
        end
        repeat (5) @(negedge clk);
        Reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            exp_an = ~(4'b0001 << (i / 4));
            vectors++;
            if (bus.an !== exp_an || bus.seg !== exp_seg[i/4] || bus.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL scan_after_reset cycle %0d an=%b seg=%h busy=%b expected an=%b seg=%h busy=0",
                         i, bus.an, bus.seg, bus.busy, exp_an, exp_seg[i/4]);
            end
        end
        $display("test_reset: scan sequence checked");
    endtask

    task automatic test_convert_255;
        logic [6:0] exp_seg [4];
        logic [6:0] s;
        bit ok;
        int high, pulses;
        exp_seg[0] = 7'h12; exp_seg[1] = 7'h12; exp_seg[2] = 7'h24; exp_seg[3] = 7'h79;
        bus.RawOutput = 8'd255;
        count_busy(high, pulses);
        vectors++;
        if (high != 9 || pulses != 1) begin
            miscompares++;
            $display("FAIL busy_255 high=%0d pulses=%0d expected high=9 pulses=1", high, pulses);
        end
        vectors++;
        if (bus.update_count !== 8'd1) begin
            miscompares++;
            $display("FAIL count_255 got=%0d expected=1", bus.update_count);
        end
        for (int k = 0; k < 4; k++) begin
            get_seg(k, s, ok);
            vectors++;
            if (!ok || s !== exp_seg[k]) begin
                miscompares++;
                $display("FAIL digit_255 d%0d seg=%h found=%b expected=%h", k, s, ok, exp_seg[k]);
            end
        end
        $display("test_convert_255: value 255 checked");
    endtask

    task automatic test_7_then_40;
        logic [6:0] exp7 [3];
        logic [6:0] exp40 [3];
        logic [6:0] s;
        bit ok;
        exp7[0]  = 7'h78; exp7[1]  = 7'h7F; exp7[2]  = 7'h7F;
        exp40[0] = 7'h40; exp40[1] = 7'h19; exp40[2] = 7'h7F;
        bus.RawOutput = 8'd7;
        repeat (20) @(negedge clk);
        vectors++;
        if (bus.update_count !== 8'd2) begin
            miscompares++;
            $display("FAIL count_7 got=%0d expected=2", bus.update_count);
        end
        for (int k = 0; k < 3; k++) begin
            get_seg(k, s, ok);
            vectors++;
            if (!ok || s !== exp7[k]) begin
                miscompares++;
                $display("FAIL digit_7 d%0d seg=%h found=%b expected=%h", k, s, ok, exp7[k]);
            end
        end
        bus.RawOutput = 8'd40;
        repeat (20) @(negedge clk);
        vectors++;
        if (bus.update_count !== 8'd3) begin
            miscompares++;
            $display("FAIL count_40 got=%0d expected=3", bus.update_count);
        end
        for (int k = 0; k < 3; k++) begin
            get_seg(k, s, ok);
            vectors++;
            if (!ok || s !== exp40[k]) begin
                miscompares++;
                $display("FAIL digit_40 d%0d seg=%h found=%b expected=%h", k, s, ok, exp40[k]);
            end
        end
        $display("test_7_then_40: values 7 and 40 checked");
    endtask

    task automatic test_back_to_back;
        logic [6:0] exp200 [4];
        logic [6:0] s;
        logic [6:0] want;
        bit ok;
        int waited;
        int seen;
        exp200[0] = 7'h40; exp200[1] = 7'h40; exp200[2] = 7'h24; exp200[3] = 7'h12;
        bus.RawOutput = 8'd12;
        repeat (3) @(negedge clk);
        bus.RawOutput = 8'd200;
        waited = 0;
        while (bus.update_count !== 8'd4 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (bus.update_count !== 8'd4) begin
            miscompares++;
            $display("FAIL count_12 got=%0d expected=4", bus.update_count);
        end
        // "12" is only on screen until the queued 200 finishes converting.
        seen = 0;
        for (int i = 0; i < 20 && bus.update_count === 8'd4; i++) begin
            case (bus.an)
                4'b1110: want = 7'h24;
                4'b1101: want = 7'h79;
                4'b1011: want = 7'h7F;
                4'b0111: want = 7'h19;
                default: want = 7'hxx;
            endcase
            vectors++;
            seen++;
            if (bus.seg !== want) begin
                miscompares++;
                $display("FAIL digit_12 an=%b seg=%h expected=%h", bus.an, bus.seg, want);
            end
            @(negedge clk);
        end
        vectors++;
        if (seen < 8) begin
            miscompares++;
            $display("FAIL window_12 cycles=%0d expected>=8", seen);
        end
        waited = 0;
        while (bus.update_count !== 8'd5 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (bus.update_count !== 8'd5) begin
            miscompares++;
            $display("FAIL count_200 got=%0d expected=5", bus.update_count);
        end
        for (int k = 0; k < 4; k++) begin
            get_seg(k, s, ok);
            vectors++;
            if (!ok || s !== exp200[k]) begin
                miscompares++;
                $display("FAIL digit_200 d%0d seg=%h found=%b expected=%h", k, s, ok, exp200[k]);
            end
        end
        $display("test_back_to_back: 12 then 200 checked");
    endtask

    task automatic test_hex;
        logic [6:0] exp_seg [4];
        logic [6:0] s;
        bit ok;
        int high, pulses;
        exp_seg[0] = 7'h0E; exp_seg[1] = 7'h08; exp_seg[2] = 7'h7F; exp_seg[3] = 7'h02;
        bus.hex_mode  = 1'b1;
        bus.RawOutput = 8'hAF;
        count_busy(high, pulses);
        vectors++;
        if (high != 9 || pulses != 1) begin
            miscompares++;
            $display("FAIL busy_hex high=%0d pulses=%0d expected high=9 pulses=1", high, pulses);
        end
        vectors++;
        if (bus.update_count !== 8'd6) begin
            miscompares++;
            $display("FAIL count_hex got=%0d expected=6", bus.update_count);
        end
        for (int k = 0; k < 4; k++) begin
            get_seg(k, s, ok);
            vectors++;
            if (!ok || s !== exp_seg[k]) begin
                miscompares++;
                $display("FAIL digit_hex d%0d seg=%h found=%b expected=%h", k, s, ok, exp_seg[k]);
            end
        end
        $display("test_hex: 0xAF in hex mode checked");
    endtask

    task automatic test_reset_mid_convert;
        logic [6:0] exp_seg [4];
        logic [6:0] s;
        bit ok;
        int high, pulses;
        exp_seg[0] = 7'h12; exp_seg[1] = 7'h00; exp_seg[2] = 7'h7F; exp_seg[3] = 7'h79;
        bus.hex_mode  = 1'b0;
        bus.RawOutput = 8'h55;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_before_reset got=%b expected=1", bus.busy);
        end
        #5 Reset = 1'b1;
        #1;
        vectors++;
        if (bus.an !== 4'b1111 || bus.busy !== 1'b0 || bus.update_count !== 8'd0) begin
            miscompares++;
            $display("FAIL async_reset an=%b busy=%b cnt=%0d expected an=1111 busy=0 cnt=0",
                     bus.an, bus.busy, bus.update_count);
        end
        repeat (5) @(negedge clk);
        Reset = 1'b0;
        count_busy(high, pulses);
        vectors++;
        if (high != 9 || pulses != 1) begin
            miscompares++;
            $display("FAIL busy_reconvert high=%0d pulses=%0d expected high=9 pulses=1", high, pulses);
        end
        vectors++;
        if (bus.update_count !== 8'd1) begin
            miscompares++;
            $display("FAIL count_reconvert got=%0d expected=1", bus.update_count);
        end
        for (int k = 0; k < 4; k++) begin
            get_seg(k, s, ok);
            vectors++;
            if (!ok || s !== exp_seg[k]) begin
                miscompares++;
                $display("FAIL digit_85 d%0d seg=%h found=%b expected=%h", k, s, ok, exp_seg[k]);
            end
        end
        $display("test_reset_mid_convert: reset and reconversion of 85 checked");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_convert_255();
        test_7_then_40();
        test_back_to_back();
        test_hex();
        test_reset_mid_convert();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
